// File: rtl/jstk_pkg.sv
// Shared constants and state types for the joystick SPI poller.
package jstk_pkg;

    localparam logic [5:0] CMD_PREFIX = 6'b100000;
    localparam logic [9:0] CENTER     = 10'd512;
    localparam int unsigned NUM_BYTES = 5;

    localparam logic [2:0] BYTE_XL  = 3'd0;
    localparam logic [2:0] BYTE_XH  = 3'd1;
    localparam logic [2:0] BYTE_YL  = 3'd2;
    localparam logic [2:0] BYTE_YH  = 3'd3;
    localparam logic [2:0] BYTE_BTN = 3'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StXfer,
        StGap,
        StTail,
        StDone
    } jstk_state_e;

    typedef enum logic [1:0] {
        BitIdle,
        BitLow,
        BitHigh
    } bit_state_e;

endpackage

// File: rtl/spi_byte_xfer.sv
// One 8-bit SPI mode-0 exchange: LOW/HIGH half-periods of CLK_DIV cycles each,
// MOSI MSB first, MISO shifted in on the last cycle of each HIGH.
module spi_byte_xfer
    import jstk_pkg::*;
#(
    parameter int unsigned CLK_DIV = 65
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] tx_byte_i,
    input  logic       miso_i,
    output logic       sclk_o,
    output logic       mosi_o,
    output logic       last_o,
    output logic [7:0] rx_byte_o
);
    localparam int unsigned DIV_W = 16;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    bit_state_e       st_q, st_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             half_end;

    assign half_end  = (cnt_q == DIV_LAST);
    // Asserted during the final HIGH cycle so the caller can move on without a dead cycle.
    assign last_o    = (st_q == BitHigh) && half_end && (bit_q == 3'd7);
    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;
    assign rx_byte_o = rx_q;

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q + 1'b1;
        bit_d  = bit_q;
        tx_d   = tx_q;
        rx_d   = rx_q;
        sclk_d = sclk_q;
        mosi_d = mosi_q;
        unique case (st_q)
            BitIdle: begin
                cnt_d = '0;
                if (start_i) begin
                    st_d   = BitLow;
                    bit_d  = '0;
                    mosi_d = tx_byte_i[7];
                    tx_d   = {tx_byte_i[6:0], 1'b0};
                end
            end
            BitLow: begin
                if (half_end) begin
                    st_d   = BitHigh;
                    cnt_d  = '0;
                    sclk_d = 1'b1;
                end
            end
            BitHigh: begin
                if (half_end) begin
                    cnt_d  = '0;
                    sclk_d = 1'b0;
                    rx_d   = {rx_q[6:0], miso_i};
                    bit_d  = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        st_d = BitIdle;
                    end else begin
                        st_d   = BitLow;
                        mosi_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                end
            end
            default: st_d = BitIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= BitIdle;
            cnt_q  <= '0;
            bit_q  <= '0;
            tx_q   <= '0;
            rx_q   <= '0;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
            tx_q   <= tx_d;
            rx_q   <= rx_d;
            sclk_q <= sclk_d;
            mosi_q <= mosi_d;
        end
    end

endmodule

// File: rtl/jstk_spi_reader.sv
// Polls the joystick over SPI every POLL_PERIOD cycles and presents X/Y/buttons
// as registered words with a one-cycle data_valid pulse.
module jstk_spi_reader
    import jstk_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 65,
    parameter int unsigned SS_SETUP    = 975,
    parameter int unsigned BYTE_GAP    = 650,
    parameter int unsigned POLL_PERIOD = 65000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] led,
    input  logic       MISO,
    output logic       SS,
    output logic       SCLK,
    output logic       MOSI,
    output logic [9:0] Data_out_X,
    output logic [9:0] Data_out_Y,
    output logic [2:0] buttons,
    output logic       data_valid
);
    localparam int unsigned WAIT_W = 20;
    localparam logic [WAIT_W-1:0] POLL_LAST  = WAIT_W'(POLL_PERIOD - 1);
    // The first LOW half-period is part of the SS-to-first-rise setup time.
    localparam logic [WAIT_W-1:0] SETUP_LAST = WAIT_W'(SS_SETUP - CLK_DIV - 1);
    localparam logic [WAIT_W-1:0] GAP_LAST   = WAIT_W'(BYTE_GAP - 1);
    localparam logic [WAIT_W-1:0] TAIL_LAST  = WAIT_W'(CLK_DIV - 1);

    jstk_state_e       st_q, st_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [2:0]        byte_q, byte_d;
    logic [7:0]        cmd_q, cmd_d;
    logic              ss_q, ss_d;
    logic [9:0]        raw_x_q, raw_x_d, raw_y_q, raw_y_d;
    logic [9:0]        x_q, x_d, y_q, y_d;
    logic [2:0]        btn_q, btn_d;
    logic              valid_q, valid_d;
    logic              miso_meta_q, miso_sync_q;
    logic              start;
    logic              xfer_last;
    logic [7:0]        rx_byte;
    logic [7:0]        tx_byte;

    assign tx_byte = (st_q == StSetup) ? cmd_q : 8'h00;

    spi_byte_xfer #(
        .CLK_DIV (CLK_DIV)
    ) u_xfer (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
        .tx_byte_i (tx_byte),
        .miso_i    (miso_sync_q),
        .sclk_o    (SCLK),
        .mosi_o    (MOSI),
        .last_o    (xfer_last),
        .rx_byte_o (rx_byte)
    );

    always_comb begin
        st_d    = st_q;
        wait_d  = wait_q + 1'b1;
        byte_d  = byte_q;
        cmd_d   = cmd_q;
        ss_d    = ss_q;
        raw_x_d = raw_x_q;
        raw_y_d = raw_y_q;
        x_d     = x_q;
        y_d     = y_q;
        btn_d   = btn_q;
        valid_d = 1'b0;
        start   = 1'b0;
        unique case (st_q)
            StIdle: begin
                if (wait_q == POLL_LAST) begin
                    st_d   = StSetup;
                    wait_d = '0;
                    ss_d   = 1'b0;
                    cmd_d  = {CMD_PREFIX, led};
                    byte_d = BYTE_XL;
                end
            end
            StSetup: begin
                if (wait_q == SETUP_LAST) begin
                    start  = 1'b1;
                    st_d   = StXfer;
                    wait_d = '0;
                end
            end
            StXfer: begin
                wait_d = '0;
                if (xfer_last) begin
                    st_d = (byte_q == BYTE_BTN) ? StTail : StGap;
                end
            end
            StGap: begin
                if (wait_q == GAP_LAST) begin
                    start  = 1'b1;
                    st_d   = StXfer;
                    wait_d = '0;
                    byte_d = byte_q + 1'b1;
                    unique case (byte_q)
                        BYTE_XL: raw_x_d[7:0] = rx_byte;
                        BYTE_XH: raw_x_d[9:8] = rx_byte[1:0];
                        BYTE_YL: raw_y_d[7:0] = rx_byte;
                        BYTE_YH: raw_y_d[9:8] = rx_byte[1:0];
                        default: ;
                    endcase
                end
            end
            StTail: begin
                if (wait_q == TAIL_LAST) begin
                    st_d   = StDone;
                    wait_d = '0;
                    ss_d   = 1'b1;
                end
            end
            StDone: begin
                st_d    = StIdle;
                wait_d  = '0;
                x_d     = raw_x_q;
                y_d     = raw_y_q;
                btn_d   = rx_byte[2:0];
                valid_d = 1'b1;
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= StIdle;
            wait_q      <= '0;
            byte_q      <= '0;
            cmd_q       <= '0;
            ss_q        <= 1'b1;
            raw_x_q     <= CENTER;
            raw_y_q     <= CENTER;
            x_q         <= CENTER;
            y_q         <= CENTER;
            btn_q       <= '0;
            valid_q     <= 1'b0;
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            wait_q      <= wait_d;
            byte_q      <= byte_d;
            cmd_q       <= cmd_d;
            ss_q        <= ss_d;
            raw_x_q     <= raw_x_d;
            raw_y_q     <= raw_y_d;
            x_q         <= x_d;
            y_q         <= y_d;
            btn_q       <= btn_d;
            valid_q     <= valid_d;
            miso_meta_q <= MISO;
            miso_sync_q <= miso_meta_q;
        end
    end

    assign SS         = ss_q;
    assign Data_out_X = x_q;
    assign Data_out_Y = y_q;
    assign buttons    = btn_q;
    assign data_valid = valid_q;

endmodule

// File: tb/tb_jstk_spi_reader.sv
// Bench for jstk_spi_reader: SPI slave model plus a timeline-based reference model.
module tb_jstk_spi_reader;
    localparam int CD = 4;
    localparam int SU = 20;
    localparam int GP = 10;
    localparam int PP = 50;
    localparam int L  = SU + 80 * CD + 4 * GP;  // SS-low length of one frame
    localparam int T  = PP + L + 1;             // frame start to next frame start

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       MISO = 1'b0;
    logic [1:0] led = 2'b11;
    logic       SS, SCLK, MOSI, data_valid;
    logic [9:0] Data_out_X, Data_out_Y;
    logic [2:0] buttons;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] pay [16][5];

    jstk_spi_reader #(
        .CLK_DIV     (CD),
        .SS_SETUP    (SU),
        .BYTE_GAP    (GP),
        .POLL_PERIOD (PP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .led        (led),
        .MISO       (MISO),
        .SS         (SS),
        .SCLK       (SCLK),
        .MOSI       (MOSI),
        .Data_out_X (Data_out_X),
        .Data_out_Y (Data_out_Y),
        .buttons    (buttons),
        .data_valid (data_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0d: got %0d, expected %0d", nm, t, act, exp);
        end
    endtask

    // Rising edge k of a frame, measured in cycles from the SS fall.
    function automatic int rise_at(input int k);
        return SU + 2 * CD * k + GP * (k / 8);
    endfunction

    function automatic int exp_sclk(input int ph);
        for (int k = 0; k < 40; k++) begin
            if (ph >= rise_at(k) && ph < rise_at(k) + CD) return 1;
        end
        return 0;
    endfunction

    // MOSI bit that must be held around rise k, or -1 outside any bit window.
    function automatic int exp_mosi(input int ph, input int ledv);
        int cmd;
        for (int k = 0; k < 40; k++) begin
            if (ph >= rise_at(k) - CD && ph < rise_at(k) + CD) begin
                cmd = (k < 8) ? 128 + ledv : 0;
                return (cmd >> (7 - k % 8)) & 1;
            end
        end
        return -1;
    endfunction

    // Reference model: cycle index since reset and the frame/data it implies.
    int t = 0;
    int cyc = 0;
    bit armed = 1'b0;
    bit first_pending = 1'b0;
    int fm = 0, mf = 0, led_f = 0, m_ph = 0;
    int ex_x = 512, ex_y = 512, ex_b = 0, ex_v = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            armed = 1'b1;
            first_pending = 1'b1;
            t = 0;
            ex_x = 512;
            ex_y = 512;
            ex_b = 0;
            ex_v = 0;
        end else if (armed) begin
            t++;
            ex_v = 0;
            if (t >= PP) begin
                m_ph = (t - PP) % T;
                if (m_ph == 0) begin
                    mf = fm;
                    fm++;
                    led_f = int'(led);
                end
                if (m_ph == L + 1) begin
                    ex_x = (int'(pay[mf][1]) % 4) * 256 + int'(pay[mf][0]);
                    ex_y = (int'(pay[mf][3]) % 4) * 256 + int'(pay[mf][2]);
                    ex_b = int'(pay[mf][4]) % 8;
                    ex_v = 1;
                end
            end
        end
    end

    // SPI slave: presents bit 7 at SS fall, shifts on SCLK falls, captures MOSI on rises.
    int fs = 0, pos = 0, rises = 0, cur = 0, fall_cyc = 0, last_len = 0, last_rises = 0;
    logic [7:0] cap [5];
    logic p_ss = 1'b1, p_sclk = 1'b0;

    initial forever begin
        @(negedge clk);
        if (p_ss && !SS) begin
            cur = fs;
            fs++;
            pos = 0;
            rises = 0;
            fall_cyc = cyc;
            for (int i = 0; i < 5; i++) cap[i] = 8'h00;
            MISO = pay[cur][0][7];
        end else if (!SS && p_sclk && !SCLK) begin
            pos++;
            if (pos < 40) MISO = pay[cur][pos / 8][7 - pos % 8];
        end
        if (!SS && !p_sclk && SCLK) begin
            if (rises < 40) cap[rises / 8] = {cap[rises / 8][6:0], MOSI};
            rises++;
        end
        if (!p_ss && SS) begin
            last_len = cyc - fall_cyc;
            last_rises = rises;
        end
        p_ss = SS;
        p_sclk = SCLK;
    end

    // Compare process: every cycle after the first reset edge.
    int c_ph = 0, c_m = 0, vcount = 0;
    bit c_in = 1'b0;
    logic c_pss = 1'b1;

    initial forever begin
        @(negedge clk);
        if (armed) begin
            c_in = (t >= PP);
            c_ph = c_in ? (t - PP) % T : -1;
            chk("ss", 32'(SS), (c_in && c_ph < L) ? 0 : 1);
            chk("sclk", 32'(SCLK), (c_in && c_ph < L) ? exp_sclk(c_ph) : 0);
            chk("data_valid", 32'(data_valid), ex_v);
            chk("data_x", 32'(Data_out_X), ex_x);
            chk("data_y", 32'(Data_out_Y), ex_y);
            chk("buttons", 32'(buttons), ex_b);
            if (c_in && c_ph < L) begin
                c_m = exp_mosi(c_ph, led_f);
                if (c_m >= 0) chk("mosi", 32'(MOSI), c_m);
            end
            if (c_pss && !SS && first_pending) begin
                chk("first_ss_fall_delay", t, 50);
                first_pending = 1'b0;
            end
            if (data_valid === 1'b1) begin
                vcount++;
                chk("frame_ss_low_len", last_len, 380);
                chk("frame_sclk_rises", last_rises, 40);
                if (vcount == 1) begin
                    chk("unpack_x_812", 32'(Data_out_X), 812);
                    chk("unpack_y_261", 32'(Data_out_Y), 261);
                    chk("unpack_btn_010", 32'(buttons), 2);
                    chk("cmd_byte0", 32'(cap[0]), 32'h83);
                    for (int i = 1; i < 5; i++) chk("cmd_byte_zero", 32'(cap[i]), 0);
                end
                if (vcount == 2) begin
                    chk("ignored_bits_x", 32'(Data_out_X), 785);
                    chk("ignored_bits_y", 32'(Data_out_Y), 546);
                    chk("ignored_bits_btn", 32'(buttons), 7);
                    chk("cmd_led_at_ss_fall", 32'(cap[0]), 32'h81);
                end
            end
            c_pss = SS;
        end
    end

    task automatic wait_t(input int n);
        while (t < n) @(negedge clk);
    endtask

    initial begin
        pay[0][0] = 8'h2C; pay[0][1] = 8'h03; pay[0][2] = 8'h05; pay[0][3] = 8'h01;
        pay[0][4] = 8'h02;
        pay[1][0] = 8'h11; pay[1][1] = 8'hFF; pay[1][2] = 8'h22; pay[1][3] = 8'hFE;
        pay[1][4] = 8'hFF;
        for (int f = 2; f < 16; f++) begin
            for (int b = 0; b < 5; b++) pay[f][b] = 8'($urandom);
        end

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ss", 32'(SS), 1);
        chk("rst_sclk", 32'(SCLK), 0);
        chk("rst_mosi", 32'(MOSI), 0);
        chk("rst_x", 32'(Data_out_X), 512);
        chk("rst_y", 32'(Data_out_Y), 512);
        chk("rst_btn", 32'(buttons), 0);
        chk("rst_valid", 32'(data_valid), 0);
        rst = 1'b0;

        wait_t(440);
        led = 2'b01;
        wait_t(600);
        led = 2'b10;

        // Reset while byte 2 of the third frame is in flight.
        wait_t(PP + 2 * T + 180);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ss", 32'(SS), 1);
        chk("midrst_sclk", 32'(SCLK), 0);
        chk("midrst_x", 32'(Data_out_X), 512);
        chk("midrst_y", 32'(Data_out_Y), 512);
        chk("midrst_btn", 32'(buttons), 0);
        chk("midrst_valid", 32'(data_valid), 0);
        rst = 1'b0;

        for (int i = 0; i < PP + 4 * T + 5; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 96) == 0) led = 2'($urandom);
        end

        chk("valid_pulse_count", vcount, 6);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jstk_spi_reader.md
# jstk_spi_reader

- SPI master that polls the joystick module over SPI.
- Unpacks the 10-bit X/Y deflections and the button bits, and presents them as registered data words with a one-cycle valid pulse.
- Sits between the board-level SPI pins and the movement-control logic, and produces its Data_in_X / Data_in_Y inputs.
- Runs on the 65 MHz pixel clock.

## Interface
Parameters:
- CLK_DIV, 65: system cycles per SCLK half-period (500 kHz at 65 MHz); legal minimum 3.
- SS_SETUP, 975: cycles from SS falling to the first SCLK rise (15 µs).
- BYTE_GAP, 650: idle cycles between bytes, SCLK low, SS low (10 µs).
- POLL_PERIOD, 65000: idle cycles with SS high between transactions (1 ms).

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- led  in  2  LED bits sent in command byte 0.
- MISO  in  1  serial data from the joystick; asynchronous.
- SS  out  1  active-low slave select.
- SCLK  out  1  SPI clock, mode 0, idle low.
- MOSI  out  1  serial command data, MSB first.
- Data_out_X  out  10  X deflection, 0..1023.
- Data_out_Y  out  10  Y deflection, 0..1023.
- buttons  out  3  button state from byte 4, bits [2:0].
- data_valid  out  1  one-cycle pulse when Data_out_X/Y/buttons update.

## Operation
- **Transaction:** SS low, then 5 bytes of 8 bits each, MSB first, then SS high.
- **MOSI bytes:**
  - byte0 = {6'b100000, led}, with led sampled when SS falls.
  - bytes 1–4 = 8'h00.
- **MISO bytes:** byte0 X[7:0], byte1 X[9:8] in bits [1:0], byte2 Y[7:0], byte3 Y[9:8] in bits [1:0], byte4 buttons in bits [2:0].
- **Unpacking:** bits [7:2] of bytes 1 and 3 and bits [7:3] of byte 4 are ignored. No saturation or scaling is applied.
- **Synchronizer:** MISO passes through a 2-flop synchronizer before sampling.
- **FSM states:**
  - IDLE: SS=1, SCLK=0; count POLL_PERIOD cycles, then go to SETUP.
  - SETUP: SS=0; count SS_SETUP cycles, then go to LOW.
  - LOW: SCLK=0 for CLK_DIV cycles, then go to HIGH.
  - HIGH: SCLK=1 for CLK_DIV cycles.
  - On the last cycle of HIGH, shift the synchronized MISO into the receive shift register.
  - After HIGH, if bit 7 of the byte is done and the byte is not the last, go to GAP; if it is byte 4, go to DONE; otherwise go to LOW.
  - GAP: SCLK=0, SS=0; count BYTE_GAP cycles; store the received byte; load the next MOSI byte; go to LOW.
  - DONE: SS=1; latch all outputs; pulse data_valid; go to IDLE.
- **MOSI timing:** MOSI changes only on entry to LOW, i.e. at SCLK falling edges or at the byte start. It holds the current bit for the full LOW + HIGH pair.
- **Counters:**
  - Wait counter, 20 bits minimum.
  - Bit counter, 3 bits; wraps 7→0 at each byte end.
  - Byte counter, 3 bits; counts 0..4 and never exceeds 4.
- **Output holding:** outputs change only in DONE. Partial transactions never update Data_out_X/Y or buttons.

## Timing
- **Reset values:**
  - SS=1, SCLK=0, MOSI=0.
  - Data_out_X=512, Data_out_Y=512 (joystick centre, so the controlled object holds still).
  - buttons=0, data_valid=0.
  - FSM in IDLE with the wait counter cleared.
- **After reset:** the first SS fall occurs POLL_PERIOD cycles after rst deasserts.
- **Per-transaction SCLK:** exactly 40 rising edges. Each half-period is exactly CLK_DIV cycles.
- **Transaction length** from SS falling to SS rising: SS_SETUP + 80·CLK_DIV + 4·BYTE_GAP cycles.
- **Output latency:** data_valid is high for exactly one cycle, in the cycle after SS rises. Data outputs are valid in that same cycle and hold until the next DONE.
- **Reset mid-transaction:** on the next edge SS=1, SCLK=0, outputs return to their reset values, and no data_valid is issued. The slave sees an aborted frame.
- **led change mid-transaction:** no effect until the next SETUP.
- **Sampling margin:** MISO changes at SCLK falling edges. The sample taken at the end of HIGH sees synchronized data that has been stable for at least CLK_DIV−2 cycles, hence the CLK_DIV ≥ 3 minimum.

## Structure
- **Shared package** `jstk_pkg`:
  - CMD_PREFIX = 6'b100000.
  - CENTER = 10'd512.
  - NUM_BYTES = 5.
  - Byte-index constants BYTE_XL..BYTE_BTN.
  - FSM state enum.
- **Sub-module `spi_byte_xfer`:**
  - Function: one 8-bit mode-0 exchange; start/done handshake; MOSI shift out, MISO shift in; owns the SCLK divider and bit counter.
  - Top level keeps the SS/gap/poll FSM, the byte counter, and unpacking.

## Test plan
Benches use a behavioural SPI slave model that shifts its MISO byte out on SCLK falling edges. Reduced parameters are used for speed: CLK_DIV=4, SS_SETUP=20, BYTE_GAP=10, POLL_PERIOD=50.

- **Reset:** assert rst → next edge SS=1, SCLK=0, X=Y=512, buttons=0, valid=0. The first SS fall comes 50 cycles after release.
- **Data unpack:** slave returns 2C,03,05,01,02 → Data_out_X=812, Data_out_Y=261, buttons=3'b010. valid is a single pulse, one cycle after SS rises.
- **Command byte:** led=2'b11 → MOSI captured as 83,00,00,00,00.
- **Frame timing:**
  - 40 SCLK rises per frame, each half-period exactly 4 cycles.
  - SS fall to first rise: 20 cycles; inter-byte low gap of 10 cycles.
  - SS low total 20+320+40 = 380 cycles.
- **Reset mid-frame:** rst during byte 2 → SS=1 next cycle, outputs back to 512/512/0, no valid. The next frame is complete and correct.
- **Ignored bits:** byte1=FF, byte3=FE, byte4=FF → X[9:8]=2'b11, Y[9:8]=2'b10, buttons=3'b111. No other bits leak into the outputs.
